// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result sources, issue-stage scoreboard hooks and register-file write port of the writeback arbiter
interface wb_arbiter_if;
  logic        s0_valid, s1_valid, s2_valid;
  logic [4:0]  s0_rd, s1_rd, s2_rd;
  logic [31:0] s0_data, s1_data, s2_data;
  logic        s0_ready, s1_ready, s2_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  RW;
  logic [31:0] DW;
  logic        RFWr;
  logic [31:0] busy;
  modport master (
    output s0_valid, s1_valid, s2_valid, s0_rd, s1_rd, s2_rd, s0_data, s1_data, s2_data, iss_valid, iss_rd,
    input  s0_ready, s1_ready, s2_ready, RW, DW, RFWr, busy
  );
  modport slave (
    input  s0_valid, s1_valid, s2_valid, s0_rd, s1_rd, s2_rd, s0_data, s1_data, s2_data, iss_valid, iss_rd,
    output s0_ready, s1_ready, s2_ready, RW, DW, RFWr, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: three-source writeback arbiter with per-source holding registers and a register busy scoreboard
module wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  wb_arbiter_if.slave bus
);
  logic [2:0]  s_valid, s_ready, load, gnt;
  logic [4:0]  s_rd [3];
  logic [31:0] s_data [3];
  logic [2:0]  hold_v_q, hold_v_d;
  logic [4:0]  hold_rd_q [3], hold_rd_d [3];
  logic [31:0] hold_data_q [3], hold_data_d [3];
  logic [1:0]  last_q, last_d, p0, p1, p2, gidx;
  logic        any;
  logic        rfwr_q, rfwr_d;
  logic [4:0]  rw_q, rw_d;
  logic [31:0] dw_q, dw_d, busy_q, busy_d;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign s_valid = {bus.s2_valid, bus.s1_valid, bus.s0_valid};
  assign s_rd = '{bus.s0_rd, bus.s1_rd, bus.s2_rd};
  assign s_data = '{bus.s0_data, bus.s1_data, bus.s2_data};
  assign {bus.s2_ready, bus.s1_ready, bus.s0_ready} = s_ready;
  assign bus.RW = rw_q;
  assign bus.DW = dw_q;
  assign bus.RFWr = rfwr_q;
  assign bus.busy = busy_q;
  always_comb begin
    p0 = RR_EN ? nxt(last_q) : 2'd0;
    p1 = nxt(p0);
    p2 = nxt(p1);
    any = |hold_v_q;
    gidx = hold_v_q[p0] ? p0 : hold_v_q[p1] ? p1 : p2;
    gnt = any ? 3'b001 << gidx : 3'b000;
    s_ready = ~hold_v_q | gnt;
    // rd==0 results complete the handshake but never occupy a slot
    load = s_valid & s_ready & {|s_rd[2], |s_rd[1], |s_rd[0]};
    for (int n = 0; n < 3; n++) begin
      hold_v_d[n] = load[n] | (hold_v_q[n] & ~gnt[n]);
      hold_rd_d[n] = load[n] ? s_rd[n] : hold_rd_q[n];
      hold_data_d[n] = load[n] ? s_data[n] : hold_data_q[n];
    end
    last_d = (RR_EN && any) ? gidx : last_q;
    rfwr_d = any;
    rw_d = any ? hold_rd_q[gidx] : rw_q;
    dw_d = any ? hold_data_q[gidx] : dw_q;
    // set after clear so a coinciding issue keeps the bit
    busy_d = ((busy_q & ~({31'b0, rfwr_q} << rw_q)) | ({31'b0, bus.iss_valid} << bus.iss_rd)) & ~32'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= '0;
      last_q <= 2'd2;
      rfwr_q <= 1'b0;
      rw_q <= '0;
      dw_q <= '0;
      busy_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      last_q <= last_d;
      rfwr_q <= rfwr_d;
      rw_q <= rw_d;
      dw_q <= dw_d;
      busy_q <= busy_d;
    end
    hold_rd_q <= hold_rd_d;
    hold_data_q <= hold_data_d;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a behavioural writeback model, for both arbitration modes
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   sel;
  int   checks = 0;
  int   failures = 0;
  logic tv [3];
  logic [4:0]  trd [3];
  logic [31:0] tdata [3];
  logic        tiv;
  logic [4:0]  tird;
  logic [2:0]  g_ready;
  logic        g_rfwr;
  logic [4:0]  g_rw;
  logic [31:0] g_dw, g_busy;
  bit          mv [3];
  logic [4:0]  mrd [3];
  logic [31:0] mdata [3];
  int          mlast;
  bit          mrfwr;
  logic [4:0]  mrw;
  logic [31:0] mdw, mbusy;
  logic [2:0]  exp_ready, got_ready, xf;

  wb_arbiter_if ia ();
  wb_arbiter_if ib ();
  wb_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ia));
  wb_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  assign ia.s0_valid = tv[0] && sel == 0;
  assign ia.s1_valid = tv[1] && sel == 0;
  assign ia.s2_valid = tv[2] && sel == 0;
  assign ib.s0_valid = tv[0] && sel == 1;
  assign ib.s1_valid = tv[1] && sel == 1;
  assign ib.s2_valid = tv[2] && sel == 1;
  assign ia.iss_valid = tiv && sel == 0;
  assign ib.iss_valid = tiv && sel == 1;
  assign {ia.s0_rd, ia.s1_rd, ia.s2_rd, ia.iss_rd} = {trd[0], trd[1], trd[2], tird};
  assign {ib.s0_rd, ib.s1_rd, ib.s2_rd, ib.iss_rd} = {trd[0], trd[1], trd[2], tird};
  assign {ia.s0_data, ia.s1_data, ia.s2_data} = {tdata[0], tdata[1], tdata[2]};
  assign {ib.s0_data, ib.s1_data, ib.s2_data} = {tdata[0], tdata[1], tdata[2]};

  always_comb begin
    g_ready = sel == 0 ? {ia.s2_ready, ia.s1_ready, ia.s0_ready} : {ib.s2_ready, ib.s1_ready, ib.s0_ready};
    g_rfwr = sel == 0 ? ia.RFWr : ib.RFWr;
    g_rw = sel == 0 ? ia.RW : ib.RW;
    g_dw = sel == 0 ? ia.DW : ib.DW;
    g_busy = sel == 0 ? ia.busy : ib.busy;
  end

  // Winner among pending sources: rotating search after the last winner, or plain s0>s1>s2
  function automatic int pick();
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = sel == 0 ? (mlast + 1 + k) % 3 : k;
      if (mv[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance one clock: record expected/observed readiness before the edge, then update the model
  task automatic step();
    int g;
    #1;
    g = pick();
    for (int n = 0; n < 3; n++) begin
      exp_ready[n] = !mv[n] || g == n;
      xf[n] = tv[n] && exp_ready[n] && !rst;
    end
    got_ready = g_ready;
    @(posedge clk);
    if (rst) begin
      mv = '{0, 0, 0};
      mlast = 2;
      mrfwr = 0;
      mrw = '0;
      mdw = '0;
      mbusy = '0;
    end else begin
      if (mrfwr) mbusy[mrw] = 1'b0;
      if (tiv && tird != 0) mbusy[tird] = 1'b1;
      mrfwr = g >= 0;
      if (g >= 0) begin
        mrw = mrd[g];
        mdw = mdata[g];
        mv[g] = 0;
        mlast = g;
      end
      for (int n = 0; n < 3; n++)
        if (xf[n] && trd[n] != 0) begin
          mv[n] = 1;
          mrd[n] = trd[n];
          mdata[n] = tdata[n];
        end
    end
    #1;
  endtask

  task automatic do_reset();
    tv = '{0, 0, 0};
    tiv = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    checks++; if (g_rfwr !== 1'b0) begin failures++; $display("FAIL reset_rfwr got=%b exp=0", g_rfwr); end
    checks++; if (g_rw !== 5'd0) begin failures++; $display("FAIL reset_rw got=%0d exp=0", g_rw); end
    checks++; if (g_dw !== 32'd0) begin failures++; $display("FAIL reset_dw got=%h exp=0", g_dw); end
    checks++; if (g_busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", g_busy); end
    checks++; if (g_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", g_ready); end
  endtask

  task automatic test_single();
    sel = 0;
    do_reset();
    tv[0] = 1; trd[0] = 5; tdata[0] = 32'h1234;
    step();
    tv[0] = 0;
    checks++; if (g_rfwr !== 1'b0) begin failures++; $display("FAIL single_t1_rfwr got=%b exp=0", g_rfwr); end
    step();
    checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'd5 || g_dw !== 32'h1234)
      begin failures++; $display("FAIL single_t2 got=%b/%0d/%h exp=1/5/1234", g_rfwr, g_rw, g_dw); end
    step();
    checks++; if (g_rfwr !== 1'b0 || g_rw !== 5'd5 || g_dw !== 32'h1234)
      begin failures++; $display("FAIL single_after got=%b/%0d/%h exp=0/5/1234", g_rfwr, g_rw, g_dw); end
  endtask

  task automatic test_contention();
    sel = 0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tv[n] = 1; trd[n] = 5'(n + 1); tdata[n] = 32'hA0 + n;
    end
    step();
    tv = '{0, 0, 0};
    checks++; if (got_ready !== 3'b111) begin failures++; $display("FAIL cont_ready got=%b exp=111", got_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'(i + 1) || g_dw !== 32'hA0 + i)
        begin failures++; $display("FAIL cont_order%0d got=%b/%0d/%h exp=1/%0d/%h", i, g_rfwr, g_rw, g_dw, i + 1, 32'hA0 + i); end
    end
    step();
    checks++; if (g_rfwr !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", g_rfwr); end
  endtask

  task automatic test_fixed();
    sel = 1;
    do_reset();
    tv[1] = 1; trd[1] = 7; tdata[1] = 32'h77;
    tv[0] = 1;
    for (int i = 0; i < 6; i++) begin
      trd[0] = 5'(10 + i); tdata[0] = i;
      step();
      tv[1] = 0;
      checks++; if (g_rfwr === 1'b1 && g_rw === 5'd7)
        begin failures++; $display("FAIL fixed_starve%0d got=rw7 exp=s0 only", i); end
      if (i > 0) begin
        checks++; if (got_ready[1] !== 1'b0) begin failures++; $display("FAIL fixed_s1_ready%0d got=%b exp=0", i, got_ready[1]); end
      end
    end
    tv[0] = 0;
    step();
    checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'd15)
      begin failures++; $display("FAIL fixed_last_s0 got=%b/%0d exp=1/15", g_rfwr, g_rw); end
    step();
    checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'd7 || g_dw !== 32'h77)
      begin failures++; $display("FAIL fixed_s1 got=%b/%0d/%h exp=1/7/77", g_rfwr, g_rw, g_dw); end
  endtask

  task automatic test_zero();
    sel = 0;
    do_reset();
    tiv = 1; tird = 4;
    step();
    tiv = 0;
    tv[1] = 1; trd[1] = 0; tdata[1] = 32'hFFFF_FFFF;
    step();
    tv[1] = 0;
    checks++; if (got_ready[1] !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", got_ready[1]); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (g_rfwr !== 1'b0 || g_busy !== 32'h10)
        begin failures++; $display("FAIL zero_nowrite%0d got=%b/%h exp=0/00000010", i, g_rfwr, g_busy); end
    end
  endtask

  task automatic test_scoreboard();
    sel = 0;
    do_reset();
    tiv = 1; tird = 9;
    step();
    tiv = 0;
    checks++; if (g_busy !== 32'h200) begin failures++; $display("FAIL sb_set got=%h exp=00000200", g_busy); end
    tv[2] = 1; trd[2] = 9; tdata[2] = 32'h99;
    step();
    tv[2] = 0;
    step();
    checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'd9) begin failures++; $display("FAIL sb_write got=%b/%0d exp=1/9", g_rfwr, g_rw); end
    tiv = 1; tird = 9;
    step();
    tiv = 0;
    checks++; if (g_busy !== 32'h200) begin failures++; $display("FAIL sb_set_wins got=%h exp=00000200", g_busy); end
    tv[2] = 1;
    step();
    tv[2] = 0;
    step();
    step();
    checks++; if (g_busy !== 32'h0) begin failures++; $display("FAIL sb_clear got=%h exp=0", g_busy); end
    tiv = 1; tird = 0;
    step();
    tiv = 0;
    checks++; if (g_busy !== 32'h0) begin failures++; $display("FAIL sb_r0 got=%h exp=0", g_busy); end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    tiv = 1; tird = 3;
    tv[0] = 1; trd[0] = 3; tdata[0] = 32'h33;
    tv[1] = 1; trd[1] = 4; tdata[1] = 32'h44;
    step();
    tiv = 0;
    tv = '{0, 0, 1}; trd[2] = 6; tdata[2] = 32'h66;
    rst = 1;
    step();
    rst = 0;
    tv[2] = 0;
    checks++; if (g_rfwr !== 1'b0 || g_busy !== 32'h0 || g_ready !== 3'b111)
      begin failures++; $display("FAIL midrst_state got=%b/%h/%b exp=0/0/111", g_rfwr, g_busy, g_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (g_rfwr !== 1'b0) begin failures++; $display("FAIL midrst_nowrite%0d got=%b exp=0", i, g_rfwr); end
    end
    tv[0] = 1; trd[0] = 1; tv[1] = 1; trd[1] = 2;
    step();
    tv = '{0, 0, 0};
    step();
    checks++; if (g_rfwr !== 1'b1 || g_rw !== 5'd1) begin failures++; $display("FAIL midrst_s0first got=%b/%0d exp=1/1", g_rfwr, g_rw); end
  endtask

  task automatic test_random(input int s);
    sel = s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 3; n++)
        if (xf[n] || !tv[n]) begin
          tv[n] = $urandom_range(0, 3) != 0;
          trd[n] = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
          tdata[n] = $urandom;
        end
      tiv = $urandom_range(0, 2) == 0;
      tird = 5'($urandom_range(0, 31));
      step();
      checks++; if (got_ready !== exp_ready) begin failures++; $display("FAIL rnd%0d_ready c%0d got=%b exp=%b", s, i, got_ready, exp_ready); end
      checks++; if (g_rfwr !== mrfwr || g_rw !== mrw || g_dw !== mdw)
        begin failures++; $display("FAIL rnd%0d_write c%0d got=%b/%0d/%h exp=%b/%0d/%h", s, i, g_rfwr, g_rw, g_dw, mrfwr, mrw, mdw); end
      checks++; if (g_busy !== mbusy) begin failures++; $display("FAIL rnd%0d_busy c%0d got=%h exp=%h", s, i, g_busy, mbusy); end
    end
    tv = '{0, 0, 0};
    tiv = 0;
  endtask

  initial begin
    rst = 1;
    sel = 0;
    tv = '{0, 0, 0};
    trd = '{0, 0, 0};
    tdata = '{0, 0, 0};
    tiv = 0;
    tird = 0;
    xf = '0;
    test_reset();
    test_single();
    test_contention();
    test_fixed();
    test_zero();
    test_scoreboard();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
